// File: rtl/axis_insert_header_pkg.sv
// Shared types and byte-count helpers for the header-insertion datapath.
package axis_insert_header_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_FLUSH
  } state_t;

  // Helpers take a fixed-width vector so any keep width up to 64 bytes fits.
  localparam int MAX_BYTES = 64;

  function automatic int popcount(input logic [MAX_BYTES-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < MAX_BYTES; i++) begin
      n += int'(v[i]);
    end
    return n;
  endfunction

  // n ones packed against bit w-1, e.g. n=2, w=4 -> 1100.
  function automatic logic [MAX_BYTES-1:0] lmask(input int n, input int w);
    logic [MAX_BYTES-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_BYTES; i++) begin
      m[i] = (i >= w - n) && (i < w);
    end
    return m;
  endfunction

endpackage

// File: rtl/axis_insert_header_out_reg.sv
// Output register stage: one registered beat, held stable while the sink stalls.
// Latency 1 cycle; accepts a new beat when empty or when the held beat drains.
module axis_insert_header_out_reg #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    beat_vld,
  input  logic [DATA_WD-1:0]      beat_dat,
  input  logic [DATA_BYTE_WD-1:0] beat_keep,
  input  logic                    beat_last,
  output logic                    beat_rdy,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out
);

  assign beat_rdy = !valid_out || ready_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_out <= 1'b0;
      data_out  <= '0;
      keep_out  <= '0;
      last_out  <= 1'b0;
    end else if (beat_rdy) begin
      valid_out <= beat_vld;
      if (beat_vld) begin
        data_out <= beat_dat;
        keep_out <= beat_keep;
        last_out <= beat_last;
      end
    end
  end

endmodule

// File: rtl/axis_insert_header.sv
// Prepends a 0..W byte header to each AXI-Stream packet, realigning payload bytes.
// Latency 1 cycle, full throughput; payload/header stall while the output beat is held.
module axis_insert_header
  import axis_insert_header_pkg::*;
#(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,
  input  logic                    valid_insert,
  input  logic [DATA_WD-1:0]      data_insert,
  input  logic [DATA_BYTE_WD-1:0] keep_insert,
  input  logic [BYTE_CNT_WD-1:0]  byte_insert_cnt,
  output logic                    ready_insert,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out
);

  localparam int CW = $clog2(DATA_BYTE_WD + 1);
  localparam logic [DATA_WD-1:0] ONES = '1;

  state_t                  state_q, state_d;
  logic [DATA_WD-1:0]      res_q, res_d;
  logic [CW-1:0]           h_q, h_d;
  logic [CW-1:0]           r_q, r_d;

  logic                    beat_vld, beat_last, beat_rdy;
  logic [DATA_WD-1:0]      beat_dat;
  logic [DATA_BYTE_WD-1:0] beat_keep;

  int h_i, k_i, hk_i, hdr_i, sh_res;

  // keep_insert is authoritative for the header length.
  logic unused_cnt;
  assign unused_cnt = ^byte_insert_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      res_q   <= '0;
      h_q     <= '0;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      h_q     <= h_d;
      r_q     <= r_d;
    end
  end

  always_comb begin
    h_i    = int'(h_q);
    k_i    = popcount(MAX_BYTES'(keep_in));
    hk_i   = h_i + k_i;
    hdr_i  = popcount(MAX_BYTES'(keep_insert));
    // The residual sits right-aligned; this shift moves it to the top of a beat.
    sh_res = 8 * (DATA_BYTE_WD - h_i);

    state_d      = state_q;
    res_d        = res_q;
    h_d          = h_q;
    r_d          = r_q;
    ready_insert = 1'b0;
    ready_in     = 1'b0;
    beat_vld     = 1'b0;
    beat_dat     = '0;
    beat_keep    = '0;
    beat_last    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Holding off until the previous last beat drains keeps packets ordered.
        ready_insert = beat_rdy;
        if (valid_insert && beat_rdy) begin
          h_d     = CW'(hdr_i);
          res_d   = data_insert & (ONES >> (8 * (DATA_BYTE_WD - hdr_i)));
          state_d = ST_STREAM;
        end
      end

      ST_STREAM: begin
        ready_in = beat_rdy;
        if (valid_in && beat_rdy) begin
          beat_vld  = 1'b1;
          beat_dat  = (res_q << sh_res) | (data_in >> (8 * h_i));
          beat_keep = '1;
          res_d     = data_in & (ONES >> sh_res);
          if (last_in) begin
            if (hk_i <= DATA_BYTE_WD) begin
              beat_last = 1'b1;
              beat_keep = DATA_BYTE_WD'(lmask(hk_i, DATA_BYTE_WD));
              state_d   = ST_IDLE;
            end else begin
              r_d     = CW'(hk_i - DATA_BYTE_WD);
              state_d = ST_FLUSH;
            end
          end
        end
      end

      ST_FLUSH: begin
        beat_vld  = 1'b1;
        beat_dat  = res_q << sh_res;
        beat_keep = DATA_BYTE_WD'(lmask(int'(r_q), DATA_BYTE_WD));
        beat_last = 1'b1;
        if (beat_rdy) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  axis_insert_header_out_reg #(
    .DATA_WD      (DATA_WD),
    .DATA_BYTE_WD (DATA_BYTE_WD)
  ) u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .beat_vld  (beat_vld),
    .beat_dat  (beat_dat),
    .beat_keep (beat_keep),
    .beat_last (beat_last),
    .beat_rdy  (beat_rdy),
    .valid_out (valid_out),
    .data_out  (data_out),
    .keep_out  (keep_out),
    .last_out  (last_out),
    .ready_out (ready_out)
  );

endmodule

// File: tb/tb_axis_insert_header.sv
// Directed scoreboard bench for axis_insert_header (32-bit data, 4-byte keep).
module tb_axis_insert_header;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_in = 1'b0;
  logic [31:0] data_in = '0;
  logic [3:0]  keep_in = '0;
  logic        last_in = 1'b0;
  logic        ready_in;
  logic        valid_insert = 1'b0;
  logic [31:0] data_insert = '0;
  logic [3:0]  keep_insert = '0;
  logic [1:0]  byte_insert_cnt = '0;
  logic        ready_insert;
  logic        valid_out;
  logic [31:0] data_out;
  logic [3:0]  keep_out;
  logic        last_out;
  logic        ready_out = 1'b1;

  always #5 clk = ~clk;

  axis_insert_header #(.DATA_WD(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .valid_in        (valid_in),
    .data_in         (data_in),
    .keep_in         (keep_in),
    .last_in         (last_in),
    .ready_in        (ready_in),
    .valid_insert    (valid_insert),
    .data_insert     (data_insert),
    .keep_insert     (keep_insert),
    .byte_insert_cnt (byte_insert_cnt),
    .ready_insert    (ready_insert),
    .valid_out       (valid_out),
    .data_out        (data_out),
    .keep_out        (keep_out),
    .last_out        (last_out),
    .ready_out       (ready_out)
  );

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic logic [31:0] kmask(input logic [3:0] k);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{k[i]}};
    return m;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  task automatic expect_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    exp_t e;
    e.d = d;
    e.k = k;
    e.l = l;
    exp_q.push_back(e);
  endtask

  task automatic send_hdr(input logic [31:0] d, input logic [3:0] k);
    int t;
    t = 0;
    valid_insert = 1'b1;
    data_insert  = d;
    keep_insert  = k;
    #1;
    while (!ready_insert && t < 200) begin
      @(negedge clk); #1;
      t++;
    end
    if (t >= 200) fail("hdr_handshake");
    @(posedge clk);
    @(negedge clk);
    valid_insert = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    int t;
    t = 0;
    valid_in = 1'b1;
    data_in  = d;
    keep_in  = k;
    last_in  = l;
    #1;
    while (!ready_in && t < 200) begin
      @(negedge clk); #1;
      t++;
    end
    if (t >= 200) fail("beat_handshake");
    @(posedge clk);
    @(negedge clk);
    valid_in = 1'b0;
    last_in  = 1'b0;
  endtask

  // Monitor: compares every accepted output beat against the scoreboard head.
  always begin
    @(negedge clk); #2;
    if (!rst && valid_out && ready_out) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_beat: got %h/%b last=%b with empty queue", data_out, keep_out, last_out);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("beat_dat",  data_out & kmask(e.k), e.d & kmask(e.k));
        chk("beat_keep", 32'(keep_out), 32'(e.k));
        chk("beat_last", 32'(last_out), 32'(e.l));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check_idle_zero(input string tag);
    chk({tag, "_valid_out"},    32'(valid_out), 32'd0);
    chk({tag, "_data_out"},     data_out, 32'd0);
    chk({tag, "_keep_out"},     32'(keep_out), 32'd0);
    chk({tag, "_last_out"},     32'(last_out), 32'd0);
    chk({tag, "_ready_in"},     32'(ready_in), 32'd0);
    chk({tag, "_ready_insert"}, 32'(ready_insert), 32'd1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    check_idle_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Header spans two output beats, residual flushed
    expect_beat(32'hBBCCDD11, 4'b1111, 1'b0);
    expect_beat(32'h22334455, 4'b1111, 1'b0);
    expect_beat(32'h66770000, 4'b1100, 1'b1);
    send_hdr(32'hAABBCCDD, 4'b0111);
    send_beat(32'h11223344, 4'b1111, 1'b0);
    send_beat(32'h55667788, 4'b1110, 1'b1);

    // Single-beat fit
    expect_beat(32'hBBCCDD11, 4'b1111, 1'b1);
    send_hdr(32'hAABBCCDD, 4'b0111);
    send_beat(32'h11223344, 4'b1000, 1'b1);

    // Full-width header: own beat, then pass-through
    expect_beat(32'hAABBCCDD, 4'b1111, 1'b0);
    expect_beat(32'h11223344, 4'b1111, 1'b0);
    expect_beat(32'h55667788, 4'b1111, 1'b1);
    send_hdr(32'hAABBCCDD, 4'b1111);
    send_beat(32'h11223344, 4'b1111, 1'b0);
    send_beat(32'h55667788, 4'b1111, 1'b1);

    // Empty header: pure pass-through
    expect_beat(32'hCAFEBABE, 4'b1111, 1'b0);
    expect_beat(32'h12340000, 4'b1100, 1'b1);
    send_hdr(32'h99999999, 4'b0000);
    send_beat(32'hCAFEBABE, 4'b1111, 1'b0);
    send_beat(32'h12345678, 4'b1100, 1'b1);

    // One-byte header, full last beat overflows into a flush beat
    expect_beat(32'hEE112233, 4'b1111, 1'b0);
    expect_beat(32'h44556677, 4'b1111, 1'b0);
    expect_beat(32'h88000000, 4'b1000, 1'b1);
    send_hdr(32'h000000EE, 4'b0001);
    send_beat(32'h11223344, 4'b1111, 1'b0);
    send_beat(32'h55667788, 4'b1111, 1'b1);

    // H+K exactly equals the beat width
    expect_beat(32'hBEEFA1A2, 4'b1111, 1'b1);
    send_hdr(32'h0000BEEF, 4'b0011);
    send_beat(32'hA1A2A3A4, 4'b1100, 1'b1);

    // Backpressure: ready_out low for 3 cycles while 0x22334455 is held
    expect_beat(32'hBBCCDD11, 4'b1111, 1'b0);
    expect_beat(32'h22334455, 4'b1111, 1'b0);
    expect_beat(32'h66778899, 4'b1111, 1'b0);
    expect_beat(32'hAABBCC00, 4'b1110, 1'b1);
    fork
      begin
        send_hdr(32'hAABBCCDD, 4'b0111);
        send_beat(32'h11223344, 4'b1111, 1'b0);
        send_beat(32'h55667788, 4'b1111, 1'b0);
        send_beat(32'h99AABBCC, 4'b1111, 1'b1);
      end
      begin
        repeat (3) @(negedge clk);
        ready_out = 1'b0;
        for (int i = 0; i < 3; i++) begin
          #2;
          chk("bp_hold_dat",   data_out, 32'h22334455);
          chk("bp_hold_valid", 32'(valid_out), 32'd1);
          chk("bp_ready_in",   32'(ready_in), 32'd0);
          @(negedge clk);
        end
        ready_out = 1'b1;
      end
    join

    // Payload before header: stalls until the header handshake
    expect_beat(32'hAB010203, 4'b1111, 1'b0);
    expect_beat(32'h04000000, 4'b1000, 1'b1);
    repeat (3) @(negedge clk);
    valid_in = 1'b1;
    data_in  = 32'h01020304;
    keep_in  = 4'b1111;
    last_in  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("order_ready_in", 32'(ready_in), 32'd0);
    end
    @(negedge clk);
    fork
      send_hdr(32'h000000AB, 4'b0001);
      send_beat(32'h01020304, 4'b1111, 1'b1);
    join

    // Reset mid-packet: held beat and residual dropped
    repeat (4) @(negedge clk);
    ready_out = 1'b0;
    send_hdr(32'hAABBCCDD, 4'b0111);
    send_beat(32'h11223344, 4'b1111, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_idle_zero("midrst");
    @(negedge clk);
    ready_out = 1'b1;

    expect_beat(32'hBBCCDD11, 4'b1111, 1'b0);
    expect_beat(32'h22334455, 4'b1111, 1'b0);
    expect_beat(32'h66770000, 4'b1100, 1'b1);
    send_hdr(32'hAABBCCDD, 4'b0111);
    send_beat(32'h11223344, 4'b1111, 1'b0);
    send_beat(32'h55667788, 4'b1110, 1'b1);

    for (int t = 0; t < 100 && exp_q.size() != 0; t++) @(negedge clk);
    chk("drain_queue", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
